// File: rtl/benes_route_sequencer.sv
// Purpose : steps a Benes network through a sequence of stored switch configurations.
// Latency : 1 cycle from command acceptance to the first entry on the select outputs.
// Backpressure : cmd_ready is low while a sequence runs; table writes during a run are dropped.
// Ports   : cfg_* write one stage row (R2M or M2R) of one table entry;
//           cmd_* start a sequence of cmd_len+1 entries, each held cmd_hold+1 cycles;
//           o_module_select / o_slot_select carry the current R2M / M2R switch settings,
//           o_sel_valid marks active cycles, o_entry the entry being driven,
//           o_busy / o_done / o_cfg_drop report run state, completion and rejected writes.
module benes_route_sequencer #(
   parameter int SIZE       = 32,
   parameter int STAGE_NUM  = 9,
   parameter int SWITCH_NUM = 16,
   parameter int CFG_DEPTH  = 16,
   localparam int AW        = $clog2(CFG_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic [AW-1:0]         cfg_addr,
   input  logic                  cfg_net,
   input  logic [3:0]            cfg_stage,
   input  logic [SWITCH_NUM-1:0] cfg_wdata,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [AW-1:0]         cmd_start,
   input  logic [AW-1:0]         cmd_len,
   input  logic [7:0]            cmd_hold,
   output logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1],
   output logic [SWITCH_NUM-1:0] o_slot_select   [0:STAGE_NUM-1],
   output logic                  o_sel_valid,
   output logic [AW-1:0]         o_entry,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_cfg_drop
);

   // Geometry sanity: the stage/switch counts must describe a SIZE-port Benes network.
   if ((SWITCH_NUM != SIZE / 2) || (STAGE_NUM != 2 * $clog2(SIZE) - 1)) begin : g_param_check
      $error("benes_route_sequencer: inconsistent SIZE/STAGE_NUM/SWITCH_NUM");
   end

   localparam logic [4:0] STG = 5'(STAGE_NUM);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nxt;

   logic [SWITCH_NUM-1:0] tbl [0:CFG_DEPTH-1][0:1][0:STAGE_NUM-1];
   logic [SWITCH_NUM-1:0] mod_rd  [0:STAGE_NUM-1];
   logic [SWITCH_NUM-1:0] slot_rd [0:STAGE_NUM-1];

   logic [AW-1:0] len_cnt;
   logic [7:0]    hold_cnt;
   logic [7:0]    hold_lat;
   logic [AW-1:0] nxt_entry;
   logic          accept, last, advance, stage_ok, wr_en;

   assign cmd_ready = (state == IDLE);
   assign o_busy    = (state == RUN);
   assign accept    = cmd_valid && (state == IDLE);
   assign last      = (state == RUN) && (hold_cnt == 8'd0) && (len_cnt == '0);
   assign advance   = (state == RUN) && (hold_cnt == 8'd0) && (len_cnt != '0);
   assign stage_ok  = ({1'b0, cfg_stage} < STG);
   assign wr_en     = cfg_we && (state == IDLE) && stage_ok;
   // Entry index wraps naturally because CFG_DEPTH is a power of two.
   assign nxt_entry = accept ? cmd_start : o_entry + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN:  if (last)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Row read for the entry about to be driven; a same-cycle write to that row
   // is forwarded so the new value is what gets loaded (write-first).
   always_comb begin
      for (int s = 0; s < STAGE_NUM; s++) begin
         mod_rd[s]  = tbl[nxt_entry][0][s];
         slot_rd[s] = tbl[nxt_entry][1][s];
         if (wr_en && (cfg_addr == nxt_entry) && (cfg_stage == 4'(s))) begin
            if (cfg_net) slot_rd[s] = cfg_wdata;
            else         mod_rd[s]  = cfg_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 0; a < CFG_DEPTH; a++)
            for (int n = 0; n < 2; n++)
               for (int s = 0; s < STAGE_NUM; s++)
                  tbl[a][n][s] <= '0;
      end else if (wr_en) begin
         for (int a = 0; a < CFG_DEPTH; a++)
            for (int n = 0; n < 2; n++)
               for (int s = 0; s < STAGE_NUM; s++)
                  if ((cfg_addr == AW'(a)) && (cfg_net == 1'(n)) && (cfg_stage == 4'(s)))
                     tbl[a][n][s] <= cfg_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGE_NUM; s++) begin
            o_module_select[s] <= '0;
            o_slot_select[s]   <= '0;
         end
         o_sel_valid <= 1'b0;
         o_entry     <= '0;
         o_done      <= 1'b0;
         o_cfg_drop  <= 1'b0;
         len_cnt     <= '0;
         hold_cnt    <= 8'd0;
         hold_lat    <= 8'd0;
      end else begin
         o_done     <= last;
         o_cfg_drop <= cfg_we && ((state == RUN) || !stage_ok);
         if (accept) begin
            o_sel_valid     <= 1'b1;
            o_entry         <= cmd_start;
            len_cnt         <= cmd_len;
            hold_cnt        <= cmd_hold;
            hold_lat        <= cmd_hold;
            o_module_select <= mod_rd;
            o_slot_select   <= slot_rd;
         end else if (state == RUN) begin
            if (hold_cnt != 8'd0) begin
               hold_cnt <= hold_cnt - 8'd1;
            end else if (advance) begin
               o_entry         <= nxt_entry;
               len_cnt         <= len_cnt - 1'b1;
               hold_cnt        <= hold_lat;
               o_module_select <= mod_rd;
               o_slot_select   <= slot_rd;
            end else begin
               // Selects and entry stay put so traffic already in the network keeps its route.
               o_sel_valid <= 1'b0;
            end
         end
      end
   end

endmodule
